// File: rtl/counter_multi.sv
// rtl/counter_multi.sv - parametrised multi-channel up/down counter bank with modulo limit and terminal-count pulse
module counter_multi #(
    parameter int          WIDTH       = 12,
    parameter int          CHANNELS    = 4,
    parameter int          SATURATE    = 0,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [CHANNELS-1:0]       i_en,
    input  logic [CHANNELS-1:0]       i_up,
    input  logic [CHANNELS-1:0]       i_clear,
    input  logic [CHANNELS-1:0]       i_load,
    input  logic [CHANNELS*WIDTH-1:0] i_load_val,
    input  logic [CHANNELS*WIDTH-1:0] i_limit,
    output logic [CHANNELS*WIDTH-1:0] o_count,
    output logic [CHANNELS-1:0]       o_tc
);

    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO    = '0;

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic [WIDTH-1:0] count_q;
        logic [WIDTH-1:0] count_d;
        logic             tc_q;
        logic             tc_d;
        logic [WIDTH-1:0] limit;
        logic [WIDTH-1:0] load_val;
        logic [WIDTH-1:0] count_inc;
        logic [WIDTH-1:0] count_dec;

        assign limit     = i_limit[n*WIDTH +: WIDTH];
        assign load_val  = i_load_val[n*WIDTH +: WIDTH];
        // Increment only used when count < limit, so it never overflows.
        assign count_inc = count_q + ONE;
        // Decrement only used when count > 0, so it never underflows.
        assign count_dec = count_q - ONE;

        // Next-state priority chain: clear, load, increment, decrement, hold.
        always_comb begin
            count_d = count_q;
            tc_d    = 1'b0;
            if (i_clear[n]) begin
                count_d = ZERO;
            end else if (i_load[n]) begin
                count_d = load_val;
            end else if (i_en[n] && i_up[n]) begin
                if (count_q < limit) begin
                    count_d = count_inc;
                    // Saturating counters flag the edge that reaches the limit.
                    if ((SATURATE != 0) && (count_inc == limit)) begin
                        tc_d = 1'b1;
                    end
                end else if (SATURATE == 0) begin
                    count_d = ZERO;
                    tc_d    = 1'b1;
                end else begin
                    // Clamp; a loaded value above the limit flags on its way down.
                    count_d = limit;
                    tc_d    = (count_q != limit);
                end
            end else if (i_en[n]) begin
                if (count_q != ZERO) begin
                    count_d = count_dec;
                    if ((SATURATE != 0) && (count_q == ONE)) begin
                        tc_d = 1'b1;
                    end
                end else if (SATURATE == 0) begin
                    count_d = limit;
                    tc_d    = 1'b1;
                end
            end
        end

        // Count and terminal-count registers with asynchronous reset.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                count_q <= RST_VAL;
                tc_q    <= 1'b0;
            end else begin
                count_q <= count_d;
                tc_q    <= tc_d;
            end
        end

        assign o_count[n*WIDTH +: WIDTH] = count_q;
        assign o_tc[n]                   = tc_q;
    end

endmodule

// File: doc/counter_multi.md
Name: counter_multi

Overview:
Parametrised multi-channel counter bank, successor to the single-channel enable/clear counter. Each channel has independent enable, direction, clear, parallel load, a runtime modulo limit, and a registered terminal-count pulse. Wrap or saturate behaviour is selected per instance. Used for event tallies, timers and address generators wherever several counters share one clock domain.

Parameters:
WIDTH, 12, bit width of each channel's count (1..32)
CHANNELS, 4, number of independent counter channels (1..16)
SATURATE, 0, 0 = modulo wrap at boundaries; 1 = clamp at boundaries
RESET_VALUE, 0, count value loaded into every channel on reset (must be <= 2^WIDTH-1)

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_en  input  CHANNELS  per-channel count enable
i_up  input  CHANNELS  per-channel direction: 1 = increment, 0 = decrement
i_clear  input  CHANNELS  per-channel synchronous clear to 0
i_load  input  CHANNELS  per-channel synchronous parallel load
i_load_val  input  CHANNELS*WIDTH  load values; channel n is in bits [n*WIDTH +: WIDTH]
i_limit  input  CHANNELS*WIDTH  per-channel terminal value, same packing; sampled every cycle
o_count  output  CHANNELS*WIDTH  registered counts, same packing
o_tc  output  CHANNELS  registered terminal-count pulse, one cycle wide

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. While i_rst=1, every o_count channel = RESET_VALUE and o_tc = 0. Release takes effect at the next rising i_clk edge.
- Channel independence: channels share no state. Each channel evaluates the priority chain below on every rising edge.
- Priority 1, clear: if i_clear[n], count <= 0 and tc <= 0.
- Priority 2, load: if i_load[n], count <= load_val and tc <= 0. The load value is taken as-is, even when it is above the limit.
- Priority 3, increment: if i_en[n] && i_up[n]:
  - count < limit: count <= count+1.
  - count >= limit, SATURATE=0: count <= 0 and tc <= 1.
  - count >= limit, SATURATE=1: count <= limit, and tc <= 1 only if count != limit (first arrival).
  - SATURATE=1 also: when count+1 == limit, tc <= 1 on that edge. Saturate mode therefore flags the edge on which count reaches limit.
- Priority 4, decrement: if i_en[n] && !i_up[n]:
  - count > 0: count <= count-1. In SATURATE=1, tc <= 1 when the result is 0.
  - count == 0, SATURATE=0: count <= limit and tc <= 1.
  - count == 0, SATURATE=1: count holds, tc <= 0.
- Otherwise: count holds and tc <= 0.
- o_tc width: o_tc is never high for two consecutive cycles unless a boundary event occurs on consecutive edges. Example: with limit=0 in wrap mode, o_tc stays high while enabled.
- Limit handling: limit is compared combinationally against the current count, so a limit change takes effect on the next edge. limit=0 in wrap-up mode yields a count constant at 0 with tc=1 every enabled cycle.
- Arithmetic: all arithmetic is unsigned WIDTH bits. No overflow beyond 2^WIDTH-1 is possible, because the limit bounds increments.
- Latency: o_count and o_tc change one clock after the controlling input is sampled. There is no combinational path from inputs to outputs.
- Reset mid-count: asserting i_rst immediately (asynchronously) forces RESET_VALUE and tc=0, regardless of the other inputs.

Test Plan:
- Reset: hold i_rst for 16 clocks with RESET_VALUE=0 and random inputs -> all o_count = 0 and o_tc = 0 throughout. Assert i_rst mid-count -> outputs go to 0 before the next edge.
- Wrap up: ch0 limit=9, en=1, up=1 for 10 clocks from 0 -> count 1..9 then 0. o_tc high only in the cycle count shows 0. After 25 clocks count = 5.
- Wrap down and hold: ch1 limit=5, down from 0 -> next count 5 with o_tc=1, then 4. Drop en for 10 clocks -> count stays 4 and o_tc=0.
- Saturate (SATURATE=1): up from 0 with limit=3 -> counts 1,2,3 then holds at 3 for 10 clocks. o_tc is high exactly one cycle, when count first shows 3. Down from 2 -> 1, 0, hold 0, with o_tc pulsing once at 0.
- Priority: same edge with clear=1, load=1 (val=7), en=1 -> count 0. Load=1 with en=1 -> count 7. Load 12 with limit=9, then up -> count 0 (wrap mode) or 9 (saturate mode).
- Channel independence: all 4 channels run different en/up/limit patterns for 100 random cycles -> each channel matches its own scoreboard model. Clearing one channel leaves the others unchanged.
